// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - two-requester round-robin arbiter driving a single spi_master command port
module spi_arbiter #(
  parameter int CMD_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic       req0_rw,
  input  logic       req1_rw,
  input  logic [7:0] req0_wdata,
  input  logic [7:0] req1_wdata,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       req0_done,
  output logic       req1_done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       spi_wr_cmd,
  output logic       spi_rd_cmd,
  output logic [7:0] mosi_data,
  input  logic [7:0] miso_data,
  input  logic       spi_cs
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END, DONE} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  mosi_q, mosi_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ready0_q, ready0_d, ready1_q, ready1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic [7:0]  cmd_cnt_q, cmd_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        cs_q;
  logic        seen_q, seen_d;
  logic        pick;
  logic        rw_sel;
  logic        cs_rise;
  logic        to_hit;

  // Next-state and registered-output logic; every output leaves a flop
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    mosi_d    = mosi_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ready0_d  = 1'b0;
    ready1_d  = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    cmd_cnt_d = cmd_cnt_q;
    to_cnt_d  = to_cnt_q;
    seen_d    = seen_q;
    // On a tie the requester not served last wins; otherwise whoever is asking
    pick      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    rw_sel    = pick ? req1_rw : req0_rw;
    cs_rise   = ~cs_q & spi_cs;
    // Counter is 0 in the first ISSUE cycle, so this edge makes it reach the limit
    to_hit    = (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d   = pick;
          last_d    = pick;
          mosi_d    = pick ? req1_wdata : req0_wdata;
          wr_d      = rw_sel;
          rd_d      = ~rw_sel;
          ready0_d  = ~pick;
          ready1_d  = pick;
          cmd_cnt_d = 8'd1;
          to_cnt_d  = 16'd0;
          seen_d    = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        to_cnt_d = to_cnt_q + 16'd1;
        if (!cs_q) seen_d = 1'b1;
        if (to_hit) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          rdata_d = 8'h00;
          err_d   = 1'b1;
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = DONE;
        end else if (cmd_cnt_q == 8'(CMD_CYCLES)) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          state_d = WAIT_END;
        end else begin
          cmd_cnt_d = cmd_cnt_q + 8'd1;
        end
      end
      WAIT_END: begin
        to_cnt_d = to_cnt_q + 16'd1;
        if (!cs_q) seen_d = 1'b1;
        // Completion is checked first so it beats a coincident timeout
        if (seen_q && cs_rise) begin
          rdata_d = miso_data;
          err_d   = 1'b0;
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = DONE;
        end else if (to_hit) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      mosi_q    <= 8'h00;
      rdata_q   <= 8'h00;
      err_q     <= 1'b0;
      ready0_q  <= 1'b0;
      ready1_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      cmd_cnt_q <= 8'd0;
      to_cnt_q  <= 16'd0;
      cs_q      <= 1'b1;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      mosi_q    <= mosi_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ready0_q  <= ready0_d;
      ready1_q  <= ready1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      cmd_cnt_q <= cmd_cnt_d;
      to_cnt_q  <= to_cnt_d;
      cs_q      <= spi_cs;
      seen_q    <= seen_d;
    end
  end

  assign req0_ready = ready0_q;
  assign req1_ready = ready1_q;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign spi_wr_cmd = wr_q;
  assign spi_rd_cmd = rd_q;
  assign mosi_data  = mosi_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter
module tb_spi_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_rw, req1_rw;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready, req0_done, req1_done;
  logic [7:0] rdata, mosi_data, miso_data;
  logic       err, spi_wr_cmd, spi_rd_cmd, spi_cs;

  logic       t_req0_valid, t_req0_rw;
  logic [7:0] t_req0_wdata, t_miso;
  logic       t_cs;
  logic       z1;
  logic [7:0] z8;
  logic       t_req0_ready, t_req1_ready, t_req0_done, t_req1_done;
  logic [7:0] t_rdata, t_mosi;
  logic       t_err, t_wr, t_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_arbiter #(.CMD_CYCLES(10), .TIMEOUT_CYCLES(1023)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_rw(req0_rw), .req1_rw(req1_rw),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_done(req0_done), .req1_done(req1_done),
    .rdata(rdata), .err(err),
    .spi_wr_cmd(spi_wr_cmd), .spi_rd_cmd(spi_rd_cmd),
    .mosi_data(mosi_data), .miso_data(miso_data), .spi_cs(spi_cs)
  );

  spi_arbiter #(.CMD_CYCLES(10), .TIMEOUT_CYCLES(50)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t_req0_valid), .req1_valid(z1),
    .req0_rw(t_req0_rw), .req1_rw(z1),
    .req0_wdata(t_req0_wdata), .req1_wdata(z8),
    .req0_ready(t_req0_ready), .req1_ready(t_req1_ready),
    .req0_done(t_req0_done), .req1_done(t_req1_done),
    .rdata(t_rdata), .err(t_err),
    .spi_wr_cmd(t_wr), .spi_rd_cmd(t_rd),
    .mosi_data(t_mosi), .miso_data(t_miso), .spi_cs(t_cs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   wr_cnt, rd_cnt, r0_cnt, r1_cnt, d0_cnt, d1_cnt, grants, since;
    logic nxt;

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_rw = 1'b0; req1_rw = 1'b0;
    req0_wdata = 8'h00; req1_wdata = 8'h00; miso_data = 8'h5A; spi_cs = 1'b1;
    t_req0_valid = 1'b0; t_req0_rw = 1'b0; t_req0_wdata = 8'h00; t_miso = 8'hEE; t_cs = 1'b1;
    z1 = 1'b0; z8 = 8'h00;
    repeat (3) tick();
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_done", 32'({req0_done, req1_done}), 32'd0);
    chk("rst_cmds", 32'({spi_wr_cmd, spi_rd_cmd}), 32'd0);
    chk("rst_mosi", 32'(mosi_data), 32'h00);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    // req0 write 0xC9, CS low 5 cycles after command start, high 200 cycles later
    req0_valid = 1'b1; req0_rw = 1'b1; req0_wdata = 8'hC9;
    tick();
    chk("w_ready0", 32'(req0_ready), 32'd1);
    chk("w_ready1", 32'(req1_ready), 32'd0);
    chk("w_mosi", 32'(mosi_data), 32'hC9);
    req0_valid = 1'b0;
    wr_cnt = 0; rd_cnt = 0;
    for (int k = 0; k <= 207; k++) begin
      if (spi_wr_cmd) wr_cnt++;
      if (spi_rd_cmd) rd_cnt++;
      if (k == 1) chk("w_ready_pulse", 32'(req0_ready), 32'd0);
      if (k == 5) spi_cs = 1'b0;
      if (k == 205) begin chk("w_done_early", 32'(req0_done), 32'd0); spi_cs = 1'b1; end
      if (k == 206) begin
        chk("w_done", 32'(req0_done), 32'd1);
        chk("w_err", 32'(err), 32'd0);
        chk("w_mosi_done", 32'(mosi_data), 32'hC9);
      end
      if (k == 207) chk("w_done_pulse", 32'(req0_done), 32'd0);
      tick();
    end
    chk("w_wr_cycles", 32'(wr_cnt), 32'd10);
    chk("w_rd_cycles", 32'(rd_cnt), 32'd0);

    // req1 read 0xA5, one-cycle CS glitch ignored, req0 valid withdrawn before ready
    req1_valid = 1'b1; req1_rw = 1'b0; req1_wdata = 8'h11; miso_data = 8'hA5;
    tick();
    chk("r_ready1", 32'(req1_ready), 32'd1);
    chk("r_cmds", 32'({spi_wr_cmd, spi_rd_cmd}), 32'b01);
    chk("r_mosi", 32'(mosi_data), 32'h11);
    req1_valid = 1'b0;
    rd_cnt = 0; r0_cnt = 0;
    for (int k = 0; k <= 23; k++) begin
      if (spi_rd_cmd) rd_cnt++;
      if (req0_ready) r0_cnt++;
      if (k == 5) req0_valid = 1'b1;
      if (k == 7) req0_valid = 1'b0;
      if (k == 11) spi_cs = 1'b0;
      if (k == 12) spi_cs = 1'b1;
      if (k == 13) chk("r_glitch_ignored", 32'(req1_done), 32'd0);
      if (k == 16) spi_cs = 1'b0;
      if (k == 20) begin chk("r_done_early", 32'(req1_done), 32'd0); spi_cs = 1'b1; end
      if (k == 21) begin
        chk("r_done", 32'({req0_done, req1_done}), 32'b01);
        chk("r_rdata", 32'(rdata), 32'hA5);
        chk("r_err", 32'(err), 32'd0);
      end
      tick();
    end
    chk("r_rd_cycles", 32'(rd_cnt), 32'd10);
    chk("r_withdrawn_no_ready", 32'(r0_cnt), 32'd0);

    // Both held: grants alternate req0, req1, req0, req1 at fixed spacing
    req0_valid = 1'b1; req0_rw = 1'b1; req0_wdata = 8'h30;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_wdata = 8'h31;
    nxt = 1'b0; grants = 0; since = -1; d0_cnt = 0; d1_cnt = 0;
    for (int c = 0; c < 120 && !(grants == 4 && since > 16); c++) begin
      if (req0_done) d0_cnt++;
      if (req1_done) d1_cnt++;
      if (req0_ready || req1_ready) begin
        chk("rr_order", 32'(req1_ready), 32'(nxt));
        chk("rr_exclusive", 32'(req0_ready & req1_ready), 32'd0);
        chk("rr_mosi", 32'(mosi_data), nxt ? 32'h31 : 32'h30);
        if (grants > 0) chk("rr_spacing", 32'(since), 32'd17);
        nxt = ~nxt; grants++; since = 0;
        if (grants == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      if (since == 3) spi_cs = 1'b0;
      if (since == 14) spi_cs = 1'b1;
      if (since >= 0) since++;
      tick();
    end
    chk("rr_grants", 32'(grants), 32'd4);
    chk("rr_dones", 32'({d0_cnt[7:0], d1_cnt[7:0]}), 32'h0202);

    // Late req1 waits while req0 is busy, then is served; reset in WAIT_END aborts it
    req0_valid = 1'b1; req0_rw = 1'b1; req0_wdata = 8'h44;
    tick();
    chk("b_ready0", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;
    r1_cnt = 0;
    for (int k = 0; k <= 29; k++) begin
      if (k == 2) begin req1_valid = 1'b1; req1_rw = 1'b1; req1_wdata = 8'h55; end
      if (k == 3) spi_cs = 1'b0;
      if (k == 14) spi_cs = 1'b1;
      if (k >= 1 && k <= 16 && req1_ready) r1_cnt++;
      if (k == 15) chk("b_done0", 32'(req0_done), 32'd1);
      if (k == 17) begin
        chk("b_ready1_served", 32'(req1_ready), 32'd1);
        chk("b_mosi", 32'(mosi_data), 32'h55);
        req1_valid = 1'b0;
      end
      if (k == 29) begin
        #2 rst_n = 1'b0;
        #1;
        chk("a_cmds", 32'({spi_wr_cmd, spi_rd_cmd}), 32'd0);
        chk("a_mosi", 32'(mosi_data), 32'h00);
        chk("a_rdata", 32'(rdata), 32'h00);
      end else begin
        tick();
      end
    end
    chk("b_no_ready_busy", 32'(r1_cnt), 32'd0);
    d0_cnt = 0; d1_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (req0_done) d0_cnt++;
      if (req1_done) d1_cnt++;
    end
    chk("a_no_done", 32'(d0_cnt + d1_cnt), 32'd0);
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_wdata = 8'h66;
    tick();
    chk("a_ready1", 32'({req0_ready, req1_ready}), 32'b01);
    chk("a_rd_cmd", 32'(spi_rd_cmd), 32'd1);
    req1_valid = 1'b0;

    // TIMEOUT=50 instance: completion coinciding with timeout wins, then a true timeout
    t_req0_valid = 1'b1; t_req0_rw = 1'b0; t_req0_wdata = 8'h21;
    tick();
    chk("c_ready0", 32'(t_req0_ready), 32'd1);
    t_req0_valid = 1'b0;
    rd_cnt = 0;
    for (int k = 0; k <= 51; k++) begin
      if (t_rd) rd_cnt++;
      if (k == 20) t_cs = 1'b0;
      if (k == 49) begin chk("c_done_early", 32'(t_req0_done), 32'd0); t_cs = 1'b1; end
      if (k == 50) begin
        chk("c_done", 32'(t_req0_done), 32'd1);
        chk("c_err", 32'(t_err), 32'd0);
        chk("c_rdata", 32'(t_rdata), 32'hEE);
      end
      tick();
    end
    chk("c_rd_cycles", 32'(rd_cnt), 32'd10);

    t_req0_valid = 1'b1; t_req0_rw = 1'b1; t_req0_wdata = 8'h77;
    tick();
    chk("t_ready0", 32'(t_req0_ready), 32'd1);
    t_req0_valid = 1'b0;
    wr_cnt = 0;
    for (int k = 0; k <= 51; k++) begin
      if (t_wr) wr_cnt++;
      if (k == 49) chk("t_done_early", 32'(t_req0_done), 32'd0);
      if (k == 50) begin
        chk("t_done", 32'(t_req0_done), 32'd1);
        chk("t_err", 32'(t_err), 32'd1);
        chk("t_rdata", 32'(t_rdata), 32'h00);
      end
      if (k == 51) chk("t_err_clear", 32'({t_req0_done, t_err}), 32'd0);
      tick();
    end
    chk("t_wr_cycles", 32'(wr_cnt), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter CMD_CYCLES, default 10: number of clk cycles spi_wr_cmd/spi_rd_cmd are held high per transfer (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1023: cycles allowed from command start to transfer end before abort (range CMD_CYCLES+2..65535).
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester i has a transfer pending; held until reqi_ready.
REQ-006 req0_rw / req1_rw  input  1  1 = write, 0 = read; sampled with valid.
REQ-007 req0_wdata / req1_wdata  input  8  byte to shift out on MOSI; sampled with valid.
REQ-008 req0_ready / req1_ready  output  1  one-cycle accept pulse to requester i.
REQ-009 req0_done / req1_done  output  1  one-cycle completion pulse to requester i.
REQ-010 rdata  output  8  byte captured from miso_data; valid in the done cycle.
REQ-011 err  output  1  high in the done cycle if the transfer timed out.
REQ-012 spi_wr_cmd  output  1  write command to spi_master.
REQ-013 spi_rd_cmd  output  1  read command to spi_master.
REQ-014 mosi_data  output  8  byte to spi_master, stable from command start to done.
REQ-015 miso_data  input  8  received byte from spi_master.
REQ-016 spi_cs  input  1  spi_master CS pin, same clock domain, low during a transfer.

Function
REQ-017 States IDLE, ISSUE, WAIT_END, DONE; all outputs registered.
REQ-018 IDLE: at an edge sampling any valid, grant, capture rw/wdata into mosi_data, go ISSUE; granted reqi_ready = 1 for exactly the first ISSUE cycle.
REQ-019 Arbitration round-robin: both valid -> grant the requester not granted last; last_grant resets to 1, so requester 0 wins the first tie.
REQ-020 ISSUE: spi_wr_cmd (rw=1) or spi_rd_cmd (rw=0) high for exactly CMD_CYCLES cycles starting the first ISSUE cycle; the other command stays 0; then WAIT_END.
REQ-021 spi_cs is registered into cs_q (reset 1); seen_low sets when cs_q = 0 during ISSUE or WAIT_END.
REQ-022 WAIT_END: when seen_low = 1 and a rising edge (cs_q = 0, spi_cs = 1) is detected, capture miso_data into rdata, go DONE.
REQ-023 Timeout counter starts at 0 on entering ISSUE, increments every cycle; reaching TIMEOUT_CYCLES in ISSUE or WAIT_END forces DONE with err = 1 and rdata = 0x00, commands deasserted that edge.
REQ-024 DONE: granted reqi_done = 1 for one cycle, err valid; next state IDLE; new grant possible no earlier than the cycle after DONE.
REQ-025 Minimum accept-to-accept spacing is CMD_CYCLES + 3 cycles.
REQ-026 Valid from the non-granted requester while busy is ignored (no ready), not lost; it is served when back in IDLE.
REQ-027 Valid deasserted before ready is legal; no grant results.
REQ-028 CS rising edge without prior low (seen_low = 0) is ignored.
REQ-029 Completion and timeout in the same cycle: completion wins, err = 0.

Reset
REQ-030 On rst_n low, immediately: state IDLE, spi_wr_cmd = spi_rd_cmd = 0, mosi_data = 0x00, rdata = 0x00, err = 0, all ready/done = 0, counters 0, cs_q = 1, seen_low = 0, last_grant = 1.
REQ-031 Reset mid-transfer aborts silently: no done pulse; first grant after release follows REQ-019.

Verification
REQ-032 req0 write 0xC9, spi_cs low 5 cycles after command start, high 200 cycles later -> spi_wr_cmd high exactly 10 cycles, mosi_data = 0xC9, req0_done 1 cycle after CS rise, err = 0.
REQ-033 req1 read, miso_data = 0xA5 at CS rise -> spi_rd_cmd high 10 cycles, req1_done with rdata = 0xA5.
REQ-034 req0 and req1 valid same cycle, held -> order req0, req1, req0, req1; ready pulses alternate, never concurrent.
REQ-035 spi_cs held high after command (TIMEOUT_CYCLES = 50) -> done at cycle 50 from ISSUE entry, err = 1, rdata = 0x00.
REQ-036 rst_n low during WAIT_END -> commands 0 asynchronously, no done; after release, req1-only valid -> req1_ready in the first ISSUE cycle.
